lcd_refresh_scheduler: RTL and testbench

Top-level sequencer for the safe's LCD write path. After power-up it waits out the LCD power-on delay and launches the init sequence on the LCD init/refresh engine. It then launches refresh sequences on demand from display-content logic (code entry, lock state) and, optionally, periodically. Sits between the display-content logic and the LCD init/refresh engine, and owns that engine's `mode`, `lcd_cnt` and `lcd_enable` inputs.

---
 rtl/lcd_refresh_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_scheduler.sv
// LCD write-path sequencer: power-on wait, init launch, on-demand refresh.
// Define LCD_SCHED_AUTOREFRESH_EN to add a periodic auto-refresh.
module lcd_refresh_scheduler #(
    parameter int         PWRUP_MS    = 20,
    parameter logic [1:0] INIT_CNT    = 2'd3,
    parameter logic [1:0] REFRESH_CNT = 2'd1,
    parameter int         TIMEOUT_MS  = 100,
    parameter int         REFRESH_MS  = 250
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       upd_req,
    input  logic       lcd_finish,
    output logic       mode,
    output logic [1:0] lcd_cnt,
    output logic       lcd_enable,
    output logic       upd_ack,
    output logic       ready,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [2:0] PWRUP     = 3'd0;
    localparam logic [2:0] INIT_GO   = 3'd1;
    localparam logic [2:0] INIT_WAIT = 3'd2;
    localparam logic [2:0] IDLE      = 3'd3;
    localparam logic [2:0] REF_GO    = 3'd4;
    localparam logic [2:0] REF_WAIT  = 3'd5;

    localparam int PW = $clog2(PWRUP_MS);
    localparam int TW = $clog2(TIMEOUT_MS);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          upd_pend_q, upd_pend_d;
    logic          serving_upd_q, serving_upd_d;
    logic          mode_q, mode_d;
    logic [1:0]    lcd_cnt_q, lcd_cnt_d;
    logic          lcd_enable_q, lcd_enable_d;
    logic          upd_ack_q, upd_ack_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic          clr_pend;
    logic          auto_pend_q;

`ifdef LCD_SCHED_AUTOREFRESH_EN
    localparam int RW = $clog2(REFRESH_MS);

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic          auto_pend_d;

    // Free-running period counter; a tick landing on REF_GO survives.
    always_comb begin
        ref_cnt_d   = ref_cnt_q;
        auto_pend_d = auto_pend_q;
        if (clr_pend) begin
            auto_pend_d = 1'b0;
        end
        if (ready_q) begin
            if (ref_cnt_q == RW'(REFRESH_MS - 1)) begin
                ref_cnt_d   = '0;
                auto_pend_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            ref_cnt_q   <= '0;
            auto_pend_q <= 1'b0;
        end else begin
            ref_cnt_q   <= ref_cnt_d;
            auto_pend_q <= auto_pend_d;
        end
    end
`else
    logic unused_refresh_ms;

    assign auto_pend_q       = 1'b0;
    assign unused_refresh_ms = ^REFRESH_MS;
`endif

    always_comb begin
        state_d       = state_q;
        pwr_cnt_d     = pwr_cnt_q;
        to_cnt_d      = to_cnt_q;
        serving_upd_d = serving_upd_q;
        ready_d       = ready_q;
        timeout_err_d = timeout_err_q;
        upd_ack_d     = 1'b0;
        clr_pend      = 1'b0;

        unique case (state_q)
            PWRUP: begin
                if (pwr_cnt_q == PW'(PWRUP_MS - 1)) begin
                    state_d = INIT_GO;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW'(1);
                end
            end
            INIT_GO: begin
                to_cnt_d = '0;
                state_d  = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (lcd_finish) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt_q == TW'(TIMEOUT_MS - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = INIT_GO;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            IDLE: begin
                if (upd_pend_q || auto_pend_q) begin
                    state_d = REF_GO;
                end
            end
            REF_GO: begin
                // A retry keeps the ack owed by the attempt it replaces.
                serving_upd_d = serving_upd_q | upd_pend_q;
                clr_pend      = 1'b1;
                to_cnt_d      = '0;
                state_d       = REF_WAIT;
            end
            REF_WAIT: begin
                if (lcd_finish) begin
                    upd_ack_d     = serving_upd_q;
                    serving_upd_d = 1'b0;
                    state_d       = IDLE;
                end else if (to_cnt_q == TW'(TIMEOUT_MS - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = REF_GO;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = PWRUP;
            end
        endcase
    end

    // Clear first so a request in the REF_GO cycle stays latched.
    always_comb begin
        upd_pend_d = upd_pend_q;
        if (clr_pend) begin
            upd_pend_d = 1'b0;
        end
        if (upd_req) begin
            upd_pend_d = 1'b1;
        end
    end

    // Outputs decode the next state so they line up with the state itself.
    always_comb begin
        mode_d       = mode_q;
        lcd_cnt_d    = lcd_cnt_q;
        lcd_enable_d = 1'b0;
        busy_d       = (state_d != IDLE);
        if (state_d == INIT_GO) begin
            mode_d       = 1'b1;
            lcd_cnt_d    = INIT_CNT;
            lcd_enable_d = 1'b1;
        end else if (state_d == REF_GO) begin
            mode_d       = 1'b0;
            lcd_cnt_d    = REFRESH_CNT;
            lcd_enable_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            state_q       <= PWRUP;
            pwr_cnt_q     <= '0;
            to_cnt_q      <= '0;
            upd_pend_q    <= 1'b0;
            serving_upd_q <= 1'b0;
            mode_q        <= 1'b1;
            lcd_cnt_q     <= INIT_CNT;
            lcd_enable_q  <= 1'b0;
            upd_ack_q     <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwr_cnt_q     <= pwr_cnt_d;
            to_cnt_q      <= to_cnt_d;
            upd_pend_q    <= upd_pend_d;
            serving_upd_q <= serving_upd_d;
            mode_q        <= mode_d;
            lcd_cnt_q     <= lcd_cnt_d;
            lcd_enable_q  <= lcd_enable_d;
            upd_ack_q     <= upd_ack_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mode        = mode_q;
    assign lcd_cnt     = lcd_cnt_q;
    assign lcd_enable  = lcd_enable_q;
    assign upd_ack     = upd_ack_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Bench for lcd_refresh_scheduler: level vectors plus a pulse scoreboard.
// Pulses (lcd_enable, upd_ack) are matched against expected-cycle queues.
module tb_lcd_refresh_scheduler;

    localparam int         PWRUP_MS    = 20;
    localparam logic [1:0] INIT_CNT    = 2'd3;
    localparam logic [1:0] REFRESH_CNT = 2'd1;

    logic       clk_1ms = 1'b0;
    logic       reset = 1'b0;
    logic       upd_req = 1'b0;
    logic       lcd_finish = 1'b0;
    logic       mode;
    logic [1:0] lcd_cnt;
    logic       lcd_enable;
    logic       upd_ack;
    logic       ready;
    logic       busy;
    logic       timeout_err;

    lcd_refresh_scheduler #(
        .PWRUP_MS    (PWRUP_MS),
        .INIT_CNT    (INIT_CNT),
        .REFRESH_CNT (REFRESH_CNT),
        .TIMEOUT_MS  (100),
        .REFRESH_MS  (250)
    ) dut (
        .clk_1ms     (clk_1ms),
        .reset       (reset),
        .upd_req     (upd_req),
        .lcd_finish  (lcd_finish),
        .mode        (mode),
        .lcd_cnt     (lcd_cnt),
        .lcd_enable  (lcd_enable),
        .upd_ack     (upd_ack),
        .ready       (ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_1ms = ~clk_1ms;

    typedef struct {
        int cyc;
        bit mode;
        int cnt;
    } en_t;

    typedef struct {
        int cyc;
        bit upd;
        bit fin;
        bit x_mode;
        int x_cnt;
        bit x_ready;
        bit x_busy;
        bit x_terr;
        int en_at;
        int ack_at;
    } vec_t;

    en_t  en_q[$];
    int   ack_q[$];
    vec_t vt[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   en_seen = 0;
    int   ack_seen = 0;
    bit   prev_en = 1'b0;

    task automatic check(string name, int got, int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, want %0d",
                      name, cyc, got, exp);
    endtask

    task automatic push_en(int c, bit m, int n);
        en_t e;
        e.cyc  = c;
        e.mode = m;
        e.cnt  = n;
        en_q.push_back(e);
    endtask

    task automatic observe();
        en_t e;
        int  a;
        if (lcd_enable === 1'b1) begin
            en_seen++;
            check("en_gap", int'(prev_en), 0);
            if (en_q.size() == 0) begin
                check("en_spurious", int'(lcd_enable), 0);
            end else begin
                e = en_q.pop_front();
                check("en_cycle", cyc, e.cyc);
                check("en_mode", int'(mode), int'(e.mode));
                check("en_cnt", int'(lcd_cnt), e.cnt);
            end
        end else if (en_q.size() != 0 && en_q[0].cyc <= cyc) begin
            e = en_q.pop_front();
            check("en_missing", int'(lcd_enable), 1);
        end
        if (upd_ack === 1'b1) begin
            ack_seen++;
            if (ack_q.size() == 0) begin
                check("ack_spurious", int'(upd_ack), 0);
            end else begin
                a = ack_q.pop_front();
                check("ack_cycle", cyc, a);
            end
        end else if (ack_q.size() != 0 && ack_q[0] <= cyc) begin
            a = ack_q.pop_front();
            check("ack_missing", int'(upd_ack), 1);
        end
        prev_en = (lcd_enable === 1'b1);
    endtask

    task automatic tick();
        @(posedge clk_1ms);
        #1;
        cyc++;
        observe();
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse(bit u, bit f);
        upd_req    = u;
        lcd_finish = f;
        tick();
        upd_req    = 1'b0;
        lcd_finish = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en_q.delete();
        ack_q.delete();
        tick();
        check("rst_mode", int'(mode), 1);
        check("rst_cnt", int'(lcd_cnt), int'(INIT_CNT));
        check("rst_en", int'(lcd_enable), 0);
        check("rst_ack", int'(upd_ack), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_terr", int'(timeout_err), 0);
        reset = 1'b0;
        cyc   = 0;
        push_en(PWRUP_MS, 1'b1, int'(INIT_CNT));
    endtask

    function automatic vec_t mk(int c, bit u, bit f, bit m, int n,
                                bit r, bit b, bit t, int e, int a);
        vec_t v;
        v.cyc = c;  v.upd = u;  v.fin = f;
        v.x_mode = m;  v.x_cnt = n;  v.x_ready = r;
        v.x_busy = b;  v.x_terr = t;
        v.en_at = e;  v.ack_at = a;
        return v;
    endfunction

    task automatic run_table();
        vt.push_back(mk(19, 0, 0, 1, 3, 0, 1, 0, -1, -1));
        vt.push_back(mk(20, 0, 0, 1, 3, 0, 1, 0, -1, -1));
        vt.push_back(mk(21, 0, 0, 1, 3, 0, 1, 0, -1, -1));
        vt.push_back(mk(30, 0, 1, 1, 3, 0, 1, 0, -1, -1));
        vt.push_back(mk(31, 0, 0, 1, 3, 1, 0, 0, -1, -1));
        vt.push_back(mk(35, 1, 0, 1, 3, 1, 0, 0, 37, -1));
        vt.push_back(mk(36, 0, 0, 1, 3, 1, 0, 0, -1, -1));
        vt.push_back(mk(37, 0, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(42, 0, 1, 0, 1, 1, 1, 0, -1, 43));
        vt.push_back(mk(43, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        vt.push_back(mk(44, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        vt.push_back(mk(50, 1, 0, 0, 1, 1, 0, 0, 52, -1));
        vt.push_back(mk(52, 0, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(53, 1, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(55, 1, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(57, 1, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(60, 0, 1, 0, 1, 1, 1, 0, 62, 61));
        vt.push_back(mk(61, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        vt.push_back(mk(62, 0, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(66, 0, 1, 0, 1, 1, 1, 0, -1, 67));
        vt.push_back(mk(67, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        vt.push_back(mk(75, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        vt.push_back(mk(80, 1, 0, 0, 1, 1, 0, 0, 82, -1));
        vt.push_back(mk(82, 1, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(85, 0, 1, 0, 1, 1, 1, 0, 87, 86));
        vt.push_back(mk(86, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        vt.push_back(mk(87, 0, 0, 0, 1, 1, 1, 0, -1, -1));
        vt.push_back(mk(90, 0, 1, 0, 1, 1, 1, 0, -1, 91));
        vt.push_back(mk(92, 0, 0, 0, 1, 1, 0, 0, -1, -1));
        foreach (vt[i]) begin
            wait_until(vt[i].cyc);
            check($sformatf("v%0d_mode", i), int'(mode), int'(vt[i].x_mode));
            check($sformatf("v%0d_cnt", i), int'(lcd_cnt), vt[i].x_cnt);
            check($sformatf("v%0d_ready", i), int'(ready), int'(vt[i].x_ready));
            check($sformatf("v%0d_busy", i), int'(busy), int'(vt[i].x_busy));
            check($sformatf("v%0d_terr", i), int'(timeout_err),
                  int'(vt[i].x_terr));
            if (vt[i].en_at >= 0) push_en(vt[i].en_at, 1'b0, int'(REFRESH_CNT));
            if (vt[i].ack_at >= 0) ack_q.push_back(vt[i].ack_at);
            pulse(vt[i].upd, vt[i].fin);
        end
    endtask

    task automatic run_timeout();
        wait_until(100);
        push_en(102, 1'b0, int'(REFRESH_CNT));
        push_en(203, 1'b0, int'(REFRESH_CNT));
        push_en(304, 1'b0, int'(REFRESH_CNT));
        pulse(1'b1, 1'b0);
        wait_until(202);
        check("to_err_pre", int'(timeout_err), 0);
        wait_until(203);
        check("to_err_set", int'(timeout_err), 1);
        check("to_busy", int'(busy), 1);
        wait_until(309);
        ack_q.push_back(310);
        pulse(1'b0, 1'b1);
        wait_until(311);
        check("to_done_busy", int'(busy), 0);
        check("to_done_terr", int'(timeout_err), 1);
        wait_until(320);
        push_en(322, 1'b0, int'(REFRESH_CNT));
        pulse(1'b1, 1'b0);
        wait_until(325);
        ack_q.push_back(326);
        pulse(1'b0, 1'b1);
        wait_until(327);
        check("to_sticky", int'(timeout_err), 1);
        check("to_idle", int'(busy), 0);
    endtask

    task automatic run_reset_mid();
        wait_until(710);
        push_en(712, 1'b0, int'(REFRESH_CNT));
        pulse(1'b1, 1'b0);
        wait_until(715);
        check("mid_busy", int'(busy), 1);
        do_reset();
        wait_until(5);
        pulse(1'b1, 1'b0);
        wait_until(19);
        check("mid_ready_pre", int'(ready), 0);
        wait_until(25);
        pulse(1'b0, 1'b1);
        wait_until(26);
        check("mid_ready", int'(ready), 1);
        check("mid_idle", int'(busy), 0);
        push_en(27, 1'b0, int'(REFRESH_CNT));
        wait_until(30);
        ack_q.push_back(31);
        pulse(1'b0, 1'b1);
        wait_until(32);
        check("mid_done", int'(busy), 0);
    endtask

    initial begin
        int e0;
        do_reset();
`ifdef LCD_SCHED_AUTOREFRESH_EN
        wait_until(30);
        pulse(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            push_en(282 + 250 * k, 1'b0, int'(REFRESH_CNT));
            wait_until(285 + 250 * k);
            pulse(1'b0, 1'b1);
        end
        wait_until(800);
        check("auto_no_ack", ack_seen, 0);
        check("auto_count", en_seen, 4);
`else
        run_table();
        run_timeout();
        e0 = en_seen;
        wait_until(700);
        check("no_auto", en_seen - e0, 0);
        run_reset_mid();
`endif
        wait_until(cyc + 5);
        check("sb_drain", en_q.size() + ack_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
